// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: word and instruction
// sizes, default PC/IMEM configuration, the per-edge fetch action and a
// saturating counter helper.
package if_stage_pkg;

  localparam int          WORD_W             = 32;
  localparam int          INSTR_BYTES        = 4;
  localparam logic [31:0] PC_RESET_DEFAULT   = 32'h0000_0000;
  localparam int          IMEM_BYTES_DEFAULT = 256;

  // What the stage does on a (non-reset) clock edge, after priority decode.
  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_FREEZE  = 2'd1,
    ACT_FLUSH   = 2'd2
  } fetch_act_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
    return (v == '1) ? v : v + WORD_W'(1);
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register: synchronous active-high reset, parallel load
// (branch redirect) that beats the load enable, and a load enable that
// is dropped by the hazard freeze.
module if_pc_reg
  import if_stage_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_next_val,
  input  logic              i_pload,
  input  logic [ADDR_W-1:0] i_pload_val,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  // PC update: reset > parallel load > enabled advance > hold.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst) begin
      r_pc <= RESET_VAL;
    end else if (i_pload) begin
      r_pc <= i_pload_val;
    end else if (i_load_en) begin
      r_pc <= i_next_val;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational
// instruction memory address and fills the IF/ID pipeline register.
// Optional build macro IF_PERF_CNT_EN adds saturating fetch/stall/flush
// performance counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] PC_RESET   = ADDR_W'(PC_RESET_DEFAULT),
  parameter int                IMEM_BYTES = IMEM_BYTES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [WORD_W-1:0] id_instr,
  output logic              id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [WORD_W-1:0] fetch_cnt,
  output logic [WORD_W-1:0] stall_cnt,
  output logic [WORD_W-1:0] flush_cnt
`endif
);

  // IMEM_BYTES is a power of two, so "mod IMEM_BYTES" is a bit mask.
  localparam logic [ADDR_W-1:0] ADDR_MASK  = ADDR_W'(IMEM_BYTES - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);

  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_branch_pc;
  fetch_act_e        w_act;

  logic [ADDR_W-1:0] r_id_pc;
  logic [WORD_W-1:0] r_id_instr;
  logic              r_id_valid;

  assign w_pc_next   = (w_pc + ADDR_W'(INSTR_BYTES)) & ADDR_MASK;
  assign w_branch_pc = branch_addr & ALIGN_MASK & ADDR_MASK;

  // Priority decode of the edge action: branch beats freeze beats advance.
  always_comb begin
    // NOTE: default first so every path assigns w_act and no latch forms.
    w_act = ACT_ADVANCE;
    if (branch_taken) begin
      w_act = ACT_FLUSH;
    end else if (freeze) begin
      w_act = ACT_FREEZE;
    end
  end

  if_pc_reg #(
    .ADDR_W    (ADDR_W),
    .RESET_VAL (PC_RESET)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .i_load_en   (!freeze),
    .i_next_val  (w_pc_next),
    .i_pload     (branch_taken),
    .i_pload_val (w_branch_pc),
    .o_pc        (w_pc)
  );

  assign imem_addr = w_pc;

  // IF/ID pipeline register: capture on advance, clear on flush, hold on freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_pc    <= '0;
      r_id_instr <= '0;
      r_id_valid <= 1'b0;
    end else begin
      case (w_act)
        ACT_FLUSH: begin
          r_id_pc    <= '0;
          r_id_instr <= '0;
          r_id_valid <= 1'b0;
        end
        ACT_ADVANCE: begin
          r_id_pc    <= w_pc_next;
          r_id_instr <= imem_instr;
          r_id_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign id_pc    = r_id_pc;
  assign id_instr = r_id_instr;
  assign id_valid = r_id_valid;

`ifdef IF_PERF_CNT_EN
  logic [WORD_W-1:0] r_fetch_cnt;
  logic [WORD_W-1:0] r_stall_cnt;
  logic [WORD_W-1:0] r_flush_cnt;

  // Saturating event counters, one per edge action.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (w_act)
        ACT_ADVANCE: r_fetch_cnt <= sat_inc(r_fetch_cnt);
        ACT_FREEZE:  r_stall_cnt <= sat_inc(r_stall_cnt);
        ACT_FLUSH:   r_flush_cnt <= sat_inc(r_flush_cnt);
        default: ;
      endcase
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
